// File: rtl/ddr5_phy_ca_pkg.sv
// Shared constants, FSM state and per-rank mode-register shadow type for the DDR5 CA tracker.
// Optional feature macro used by the top: CA_PARITY_EN.
package ddr5_phy_ca_pkg;

    localparam logic [4:0] CMD_MRW = 5'b00101;
    localparam logic [4:0] CMD_WR  = 5'b01101;

    localparam logic [7:0] MR_IDX_0  = 8'd0;
    localparam logic [7:0] MR_IDX_8  = 8'd8;
    localparam logic [7:0] MR_IDX_50 = 8'd50;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MRW_2ND,
        ST_WR_2ND
    } ca_state_e;

    typedef struct packed {
        logic [1:0] bl;
        logic [7:0] pre_pattern;
        logic [2:0] num_pre;
        logic [1:0] num_post;
        logic       crc_en;
    } mr_shadow_t;

    localparam mr_shadow_t MR_SHADOW_DEFAULT = '{
        bl:          2'b00,
        pre_pattern: 8'b00000010,
        num_pre:     3'b010,
        num_post:    2'b01,
        crc_en:      1'b0
    };

    localparam int SHADOW_W = $bits(mr_shadow_t);

endpackage

// File: rtl/ddr5_phy_mr_shadow.sv
// One rank's shadow of the write-relevant MR0/MR8/MR50 fields, updated by an accepted MRW.
module ddr5_phy_mr_shadow
    import ddr5_phy_ca_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                wr_en_i,
    input  logic [7:0]          mr_i,
    input  logic [7:0]          op_i,
    output logic [SHADOW_W-1:0] shadow_o
);

    mr_shadow_t shadow_q;
    mr_shadow_t shadow_d;

    // NOTE: every field starts from its held value so no decode path can infer a latch.
    always_comb begin
        shadow_d = shadow_q;
        if (wr_en_i) begin
            case (mr_i)
                MR_IDX_0: shadow_d.bl = op_i[1:0];
                MR_IDX_8: begin
                    case (op_i[4:3])
                        2'b01: begin
                            shadow_d.pre_pattern = 8'b00000010;
                            shadow_d.num_pre     = 3'b010;
                        end
                        2'b10: begin
                            shadow_d.pre_pattern = 8'b00000010;
                            shadow_d.num_pre     = 3'b011;
                        end
                        2'b11: begin
                            shadow_d.pre_pattern = 8'b00001010;
                            shadow_d.num_pre     = 3'b100;
                        end
                        default: ;
                    endcase
                    shadow_d.num_post = op_i[7] ? 2'b10 : 2'b01;
                end
                MR_IDX_50: shadow_d.crc_en = op_i[2] | op_i[1];
                default: ;
            endcase
        end
    end

    // NOTE: the shadow is architectural state read by the write path, so it is reset to JEDEC defaults.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shadow_q <= MR_SHADOW_DEFAULT;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    assign shadow_o = shadow_q;

endmodule

// File: rtl/ddr5_phy_ca_tracker.sv
// DDR5 PHY CA path: delays DFI CA/CS to the DRAM, decodes MRW/WRITE and presents per-rank write settings.
// Define CA_PARITY_EN to add ca_parity_o, the even parity of command_address_o.
module ddr5_phy_ca_tracker
    import ddr5_phy_ca_pkg::*;
#(
    parameter int  pNUM_RANK = 2,
    parameter int  pCA_WIDTH = 14,
    parameter int  pCA_DELAY = 1,
    localparam int RANK_W    = (pNUM_RANK > 1) ? $clog2(pNUM_RANK) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 enable_i,
    input  logic [pCA_WIDTH-1:0] dfi_address_i,
    input  logic [pNUM_RANK-1:0] dfi_cs_i,
    output logic [pNUM_RANK-1:0] chip_select_o,
    output logic [pCA_WIDTH-1:0] command_address_o,
    output logic                 wr_valid_o,
    output logic [RANK_W-1:0]    wr_rank_o,
    output logic [1:0]           burst_length_o,
    output logic [7:0]           pre_pattern_o,
    output logic [2:0]           num_pre_cycle_o,
    output logic [1:0]           num_post_cycle_o,
    output logic                 dram_crc_en_o,
`ifdef CA_PARITY_EN
    output logic                 ca_parity_o,
`endif
    output logic                 proto_err_o
);

    logic [pCA_WIDTH-1:0] ca_stage_in [pCA_DELAY];
    logic [pCA_WIDTH-1:0] ca_pipe_q   [pCA_DELAY];
    logic [pNUM_RANK-1:0] cs_stage_in [pCA_DELAY];
    logic [pNUM_RANK-1:0] cs_pipe_q   [pCA_DELAY];

    always_comb begin
        ca_stage_in[0] = dfi_address_i;
        cs_stage_in[0] = dfi_cs_i;
        for (int i = 1; i < pCA_DELAY; i++) begin
            ca_stage_in[i] = ca_pipe_q[i-1];
            cs_stage_in[i] = cs_pipe_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < pCA_DELAY; i++) begin
            if (rst_i) begin
                ca_pipe_q[i] <= '0;
                cs_pipe_q[i] <= '1;
            end else if (enable_i) begin
                ca_pipe_q[i] <= ca_stage_in[i];
                cs_pipe_q[i] <= cs_stage_in[i];
            end
        end
    end

    assign command_address_o = ca_pipe_q[pCA_DELAY-1];
    assign chip_select_o     = cs_pipe_q[pCA_DELAY-1];

`ifdef CA_PARITY_EN
    logic ca_parity_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ca_parity_q <= 1'b0;
        end else if (enable_i) begin
            ca_parity_q <= ^ca_stage_in[pCA_DELAY-1];
        end
    end

    assign ca_parity_o = ca_parity_q;
`else
    // No parity stage in this build.
`endif

    ca_state_e            state_q, state_d;
    logic [pNUM_RANK-1:0] mask_q, mask_d;
    logic [7:0]           mr_q, mr_d;
    logic [RANK_W-1:0]    rank_q, rank_d;
    logic [RANK_W-1:0]    wr_rank_q, wr_rank_d;
    mr_shadow_t           wr_out_q, wr_out_d;
    logic                 wr_valid_q, wr_valid_d;
    logic                 proto_err_q, proto_err_d;
    logic [pNUM_RANK-1:0] shadow_wr_en;
    logic [RANK_W-1:0]    low_rank;
    logic                 decode_first;
    logic [SHADOW_W-1:0]  shadow_bits [pNUM_RANK];
    mr_shadow_t           shadow [pNUM_RANK];

    for (genvar r = 0; r < pNUM_RANK; r++) begin : g_rank
        ddr5_phy_mr_shadow u_shadow (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .wr_en_i  (shadow_wr_en[r] & enable_i),
            .mr_i     (mr_q),
            .op_i     (dfi_address_i[7:0]),
            .shadow_o (shadow_bits[r])
        );
        assign shadow[r] = mr_shadow_t'(shadow_bits[r]);
    end

    // WRITE targets the lowest-index rank whose CS is asserted.
    always_comb begin
        low_rank = '0;
        for (int i = pNUM_RANK - 1; i >= 0; i--) begin
            if (!dfi_cs_i[i]) low_rank = RANK_W'(i);
        end
    end

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        mr_d         = mr_q;
        rank_d       = rank_q;
        wr_rank_d    = wr_rank_q;
        wr_out_d     = wr_out_q;
        wr_valid_d   = 1'b0;
        proto_err_d  = 1'b0;
        shadow_wr_en = '0;
        decode_first = 1'b0;

        case (state_q)
            ST_IDLE: decode_first = 1'b1;
            ST_MRW_2ND: begin
                if (&dfi_cs_i) begin
                    if (!dfi_address_i[10]) shadow_wr_en = mask_q;
                    state_d = ST_IDLE;
                end else begin
                    proto_err_d  = 1'b1;
                    decode_first = 1'b1;
                end
            end
            ST_WR_2ND: begin
                if (&dfi_cs_i) begin
                    wr_out_d = shadow[rank_q];
                    if (dfi_address_i[5]) wr_out_d.bl = 2'b00;
                    wr_rank_d  = rank_q;
                    wr_valid_d = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    proto_err_d  = 1'b1;
                    decode_first = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A malformed second cycle is re-decoded as a fresh first cycle.
        if (decode_first) begin
            state_d = ST_IDLE;
            if (!(&dfi_cs_i) && dfi_address_i[4:0] == CMD_MRW) begin
                mask_d  = ~dfi_cs_i;
                mr_d    = dfi_address_i[12:5];
                state_d = ST_MRW_2ND;
            end else if (!(&dfi_cs_i) && dfi_address_i[4:0] == CMD_WR) begin
                rank_d  = low_rank;
                state_d = ST_WR_2ND;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            mask_q      <= '0;
            mr_q        <= '0;
            rank_q      <= '0;
            wr_rank_q   <= '0;
            wr_out_q    <= MR_SHADOW_DEFAULT;
            wr_valid_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end else if (enable_i) begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            mr_q        <= mr_d;
            rank_q      <= rank_d;
            wr_rank_q   <= wr_rank_d;
            wr_out_q    <= wr_out_d;
            wr_valid_q  <= wr_valid_d;
            proto_err_q <= proto_err_d;
        end else begin
            wr_valid_q  <= 1'b0;
            proto_err_q <= 1'b0;
        end
    end

    assign wr_valid_o       = wr_valid_q;
    assign proto_err_o      = proto_err_q;
    assign wr_rank_o        = wr_rank_q;
    assign burst_length_o   = wr_out_q.bl;
    assign pre_pattern_o    = wr_out_q.pre_pattern;
    assign num_pre_cycle_o  = wr_out_q.num_pre;
    assign num_post_cycle_o = wr_out_q.num_post;
    assign dram_crc_en_o    = wr_out_q.crc_en;

endmodule

// File: tb/tb_ddr5_phy_ca_tracker.sv
// Directed bench for ddr5_phy_ca_tracker: scoreboarded WRITE results, per-cycle pipeline and pulse checks.
module tb_ddr5_phy_ca_tracker;

    localparam int NR    = 2;
    localparam int CAW   = 14;
    localparam int DELAY = 1;

    typedef struct packed {
        logic [1:0] bl;
        logic [7:0] pat;
        logic [2:0] pre;
        logic [1:0] post;
        logic       crc;
    } shadow_m_t;

    typedef struct packed {
        logic      rank;
        shadow_m_t s;
    } wr_rec_t;

    localparam shadow_m_t JEDEC_DEF = '{bl: 2'b00, pat: 8'h02, pre: 3'd2, post: 2'd1, crc: 1'b0};

    logic            clk_i = 1'b0;
    logic            rst_i = 1'b1;
    logic            enable_i = 1'b1;
    logic [CAW-1:0]  dfi_address_i = '0;
    logic [NR-1:0]   dfi_cs_i = '1;
    logic [NR-1:0]   chip_select_o;
    logic [CAW-1:0]  command_address_o;
    logic            wr_valid_o;
    logic            wr_rank_o;
    logic [1:0]      burst_length_o;
    logic [7:0]      pre_pattern_o;
    logic [2:0]      num_pre_cycle_o;
    logic [1:0]      num_post_cycle_o;
    logic            dram_crc_en_o;
    logic            proto_err_o;

    int n_checks = 0;
    int n_err    = 0;

    shadow_m_t   model [NR];
    wr_rec_t     sb [$];
    wr_rec_t     lw;
    logic [15:0] hist [$];
    logic [15:0] last_pipe;

    ddr5_phy_ca_tracker #(
        .pNUM_RANK (NR),
        .pCA_WIDTH (CAW),
        .pCA_DELAY (DELAY)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .enable_i         (enable_i),
        .dfi_address_i    (dfi_address_i),
        .dfi_cs_i         (dfi_cs_i),
        .chip_select_o    (chip_select_o),
        .command_address_o(command_address_o),
        .wr_valid_o       (wr_valid_o),
        .wr_rank_o        (wr_rank_o),
        .burst_length_o   (burst_length_o),
        .pre_pattern_o    (pre_pattern_o),
        .num_pre_cycle_o  (num_pre_cycle_o),
        .num_post_cycle_o (num_post_cycle_o),
        .dram_crc_en_o    (dram_crc_en_o),
        .proto_err_o      (proto_err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input logic exp_wv, input logic exp_pe);
        check("pipe_cs_ca", 32'({chip_select_o, command_address_o}), 32'(last_pipe));
        check("wr_valid",   32'(wr_valid_o),       32'(exp_wv));
        check("proto_err",  32'(proto_err_o),      32'(exp_pe));
        check("wr_rank",    32'(wr_rank_o),        32'(lw.rank));
        check("burst_len",  32'(burst_length_o),   32'(lw.s.bl));
        check("pre_pat",    32'(pre_pattern_o),    32'(lw.s.pat));
        check("num_pre",    32'(num_pre_cycle_o),  32'(lw.s.pre));
        check("num_post",   32'(num_post_cycle_o), 32'(lw.s.post));
        check("crc_en",     32'(dram_crc_en_o),    32'(lw.s.crc));
    endtask

    // One clock: drive at the falling edge, let the rising edge sample, observe at the next falling edge.
    task automatic cycle(input logic [1:0] cs, input logic [13:0] ca, input logic en,
                         input logic exp_wv, input logic exp_pe);
        dfi_cs_i      = cs;
        dfi_address_i = ca;
        enable_i      = en;
        if (en) begin
            hist.push_back({cs, ca});
            last_pipe = hist.pop_front();
        end
        if (exp_wv) lw = sb.pop_front();
        @(posedge clk_i);
        @(negedge clk_i);
        check_outputs(exp_wv, exp_pe);
    endtask

    task automatic do_reset();
        rst_i         = 1'b1;
        enable_i      = 1'b1;
        dfi_cs_i      = '1;
        dfi_address_i = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        for (int r = 0; r < NR; r++) model[r] = JEDEC_DEF;
        lw.rank = 1'b0;
        lw.s    = JEDEC_DEF;
        hist.delete();
        for (int i = 0; i < DELAY - 1; i++) hist.push_back({2'b11, 14'h0});
        last_pipe = {2'b11, 14'h0};
        check_outputs(1'b0, 1'b0);
        rst_i = 1'b0;
    endtask

    task automatic model_mrw(input logic [1:0] mask, input logic [7:0] mr, input logic [7:0] op);
        for (int r = 0; r < NR; r++) begin
            if (mask[r]) begin
                if (mr == 8'd0) model[r].bl = op[1:0];
                if (mr == 8'd8) begin
                    if (op[4:3] == 2'b01) begin model[r].pat = 8'h02; model[r].pre = 3'd2; end
                    if (op[4:3] == 2'b10) begin model[r].pat = 8'h02; model[r].pre = 3'd3; end
                    if (op[4:3] == 2'b11) begin model[r].pat = 8'h0A; model[r].pre = 3'd4; end
                    model[r].post = op[7] ? 2'd2 : 2'd1;
                end
                if (mr == 8'd50) model[r].crc = op[2] | op[1];
            end
        end
    endtask

    task automatic mrw(input logic [1:0] mask, input logic [7:0] mr, input logic [7:0] op, input logic cancel);
        cycle(~mask, {1'b0, mr, 5'b00101}, 1'b1, 1'b0, 1'b0);
        cycle(2'b11, {3'b000, cancel, 2'b00, op}, 1'b1, 1'b0, 1'b0);
        if (!cancel) model_mrw(mask, mr, op);
    endtask

    task automatic wr(input int rank, input logic ca5);
        wr_rec_t    rec;
        logic [1:0] cs;
        cs       = 2'b11;
        cs[rank] = 1'b0;
        cycle(cs, {9'b0, 5'b01101}, 1'b1, 1'b0, 1'b0);
        rec.rank = rank[0];
        rec.s    = model[rank];
        if (ca5) rec.s.bl = 2'b00;
        sb.push_back(rec);
        cycle(2'b11, {8'b0, ca5, 5'b0}, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        @(negedge clk_i);
        do_reset();

        // Idle traffic, including an MRW opcode with no CS asserted.
        cycle(2'b11, 14'h1234, 1'b1, 1'b0, 1'b0);
        cycle(2'b11, 14'h3FFF, 1'b1, 1'b0, 1'b0);
        cycle(2'b11, 14'h0005, 1'b1, 1'b0, 1'b0);

        mrw(2'b01, 8'd8, 8'b10011000, 1'b0);
        wr(0, 1'b1);

        mrw(2'b10, 8'd0, 8'h02, 1'b0);
        wr(1, 1'b0);
        wr(0, 1'b0);

        mrw(2'b01, 8'd50, 8'h02, 1'b1);
        wr(0, 1'b0);
        mrw(2'b01, 8'd50, 8'h02, 1'b0);
        wr(0, 1'b0);
        mrw(2'b10, 8'd50, 8'h04, 1'b0);
        wr(1, 1'b1);

        // Multicast, reserved MR8 preamble code, and an unrelated MR.
        mrw(2'b11, 8'd0, 8'h01, 1'b0);
        wr(0, 1'b0);
        wr(1, 1'b0);
        mrw(2'b01, 8'd8, 8'h00, 1'b0);
        wr(0, 1'b1);
        mrw(2'b11, 8'd9, 8'hFF, 1'b0);
        wr(1, 1'b0);

        // WRITE interrupted by an MRW first cycle.
        cycle(2'b10, {9'b0, 5'b01101}, 1'b1, 1'b0, 1'b0);
        cycle(2'b10, {1'b0, 8'd0, 5'b00101}, 1'b1, 1'b0, 1'b1);
        cycle(2'b11, {6'b0, 8'h03}, 1'b1, 1'b0, 1'b0);
        model_mrw(2'b01, 8'd0, 8'h03);
        wr(0, 1'b0);

        // MRW interrupted by a non-command cycle: pending MRW dropped.
        cycle(2'b01, {1'b0, 8'd0, 5'b00101}, 1'b1, 1'b0, 1'b0);
        cycle(2'b10, 14'h0000, 1'b1, 1'b0, 1'b1);
        cycle(2'b11, {6'b0, 8'h00}, 1'b1, 1'b0, 1'b0);
        wr(1, 1'b0);

        // Enable low for three cycles in the middle of an MRW.
        cycle(2'b01, {1'b0, 8'd8, 5'b00101}, 1'b1, 1'b0, 1'b0);
        cycle(2'b11, 14'h0400, 1'b0, 1'b0, 1'b0);
        cycle(2'b00, {9'b0, 5'b01101}, 1'b0, 1'b0, 1'b0);
        cycle(2'b11, 14'h2AAA, 1'b0, 1'b0, 1'b0);
        cycle(2'b11, {6'b0, 8'b00010000}, 1'b1, 1'b0, 1'b0);
        model_mrw(2'b10, 8'd8, 8'b00010000);
        wr(1, 1'b1);
        wr(1, 1'b0);

        // Reset between the two halves of an MRW abandons it.
        cycle(2'b10, {1'b0, 8'd0, 5'b00101}, 1'b1, 1'b0, 1'b0);
        do_reset();
        cycle(2'b11, {6'b0, 8'h02}, 1'b1, 1'b0, 1'b0);
        wr(0, 1'b0);

        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ddr5_phy_ca_tracker.md
Name: ddr5_phy_ca_tracker

Overview:
Parametrised successor of the PHY command/address path. Forwards DFI CA/CS to the DRAM interface through a configurable pipeline and decodes two-cycle MRW and WRITE commands. Keeps a per-rank shadow of MR0/MR8/MR50 write-relevant fields. For each WRITE it presents the target rank's burst length, preamble, postamble and CRC settings to the write data block.

Parameters:
pNUM_RANK, 2, number of ranks (1..4); CS bits are active low.
pCA_WIDTH, 14, CA bus width (fixed at 14 for DDR5; 7 reserved for a future DDP mode).
pCA_DELAY, 1, register stages from dfi_* to command_address_o/chip_select_o (1..4).

Ports:
clk_i  in  1  single clock.
rst_i  in  1  reset: synchronous, active-high.
enable_i  in  1  global enable; low freezes all state.
dfi_address_i  in  pCA_WIDTH  DFI command/address.
dfi_cs_i  in  pNUM_RANK  DFI chip select, active low.
chip_select_o  out  pNUM_RANK  delayed CS to DRAM.
command_address_o  out  pCA_WIDTH  delayed CA to DRAM.
wr_valid_o  out  1  one-cycle pulse per accepted WRITE.
wr_rank_o  out  max(1,$clog2(pNUM_RANK))  rank index of the last WRITE.
burst_length_o  out  2  effective BL of the last WRITE.
pre_pattern_o  out  8  preamble pattern of the last WRITE's rank.
num_pre_cycle_o  out  3  preamble cycles.
num_post_cycle_o  out  2  postamble cycles.
dram_crc_en_o  out  1  write CRC enable.
proto_err_o  out  1  one-cycle pulse on a malformed two-cycle command.

Behaviour:
- Reset (sync, rst_i=1): pipeline CA=0, CS=all ones. FSM=IDLE. wr_valid_o=0, wr_rank_o=0, proto_err_o=0. Every rank's shadow and the write outputs take JEDEC defaults: BL=2'b00, pattern=8'b00000010, pre=3'b010, post=2'b01, crc=0. Defaults apply directly at reset; there is no first-cycle default flag. A reset mid-command abandons the command.
- enable_i=0: pipeline, FSM, shadows and outputs hold; pulses forced to 0.
- Pipeline: command_address_o/chip_select_o equal dfi_* delayed by exactly pCA_DELAY enabled cycles.
- FSM states: IDLE, MRW_2ND, WR_2ND. Decode runs on the undelayed dfi_* inputs.
  - IDLE: if any CS bit is low and CA[4:0]=5'b00101, latch the target mask (~dfi_cs_i) and MR=CA[12:5], then go to MRW_2ND. If any CS bit is low and CA[4:0]=5'b01101, latch the target rank (lowest-index low CS bit), then go to WR_2ND. Otherwise stay in IDLE.
  - MRW_2ND: if all CS bits are high and CA[10]=0, apply OP=CA[7:0] to every rank in the latched mask, then go to IDLE. If all CS are high and CA[10]=1, the command is cancelled: no update, go to IDLE.
  - WR_2ND: if all CS bits are high, BL = CA[5] ? 2'b00 : shadow[rank].BL. Load all write outputs from the rank's shadow, set wr_rank_o, pulse wr_valid_o, go to IDLE.
  - Second cycle with any CS bit low: pulse proto_err_o, drop the pending command, and decode this cycle as a new IDLE first cycle.
- MR decode:
  - MR0: BL=OP[1:0].
  - MR8, OP[4:3]: 01 gives pattern 8'b00000010, pre=2. 10 gives pattern 8'b00000010, pre=3. 11 gives pattern 8'b00001010, pre=4. 00 is reserved; the preamble fields hold.
  - MR8, OP[7]: 0 gives post=2'b01; 1 gives post=2'b10.
  - MR50: crc=OP[2]|OP[1].
  - Any other MR: no effect.
- Latency: shadow updates on the edge that samples the MRW second cycle. A WRITE whose first cycle follows on the next cycle sees the new values. Write outputs and wr_valid_o register on the edge sampling the WRITE second cycle; they are visible alongside that cycle on command_address_o when pCA_DELAY=1. Write outputs hold until the next WRITE.
- Multicast MRW (several CS low) updates all selected ranks in the same cycle.

Optional Feature:
Macro CA_PARITY_EN.
- Defined: adds output ca_parity_o (1 bit), the even parity (XOR) of the delayed command_address_o, registered in the same final stage so it is cycle-aligned with command_address_o. Reset value is 0; it holds when enable_i=0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package ddr5_phy_ca_pkg holds:
  - CMD_MRW=5'b00101 and CMD_WR=5'b01101;
  - MR index constants 0/8/50;
  - the FSM state enum;
  - struct mr_shadow_t {bl, pre_pattern, num_pre, num_post, crc_en} and its JEDEC default constant.
- Sub-module ddr5_phy_mr_shadow: one rank's shadow register plus the MR0/8/50 decode, with inputs (wr_en, mr, op). It is instantiated pNUM_RANK times.

Test Plan:
1. Reset, then idle: all outputs equal the JEDEC defaults; command_address_o follows the input after pCA_DELAY cycles.
2. MRW rank0 MR8 OP=8'b10011000, then WRITE rank0 with CA5=1: wr_valid_o pulses, pattern=8'b00001010, pre=3'b100, post=2'b10, BL=2'b00.
3. MRW rank1 MR0 OP=8'h02, then WRITE rank1 with CA5=0: BL=2'b10, wr_rank_o=1. WRITE rank0 with CA5=0 gives BL=2'b00.
4. MRW MR50 OP=8'h02 with second cycle CA[10]=1 (cancel): no CRC change. The repeat without cancel gives dram_crc_en_o=1 on the next WRITE.
5. WRITE first cycle followed by a second cycle with CS low carrying an MRW opcode: proto_err_o pulses, the MRW is accepted, no wr_valid_o.
6. enable_i low for 3 cycles in the middle of an MRW: state is frozen; the command completes correctly after enable_i returns high.
